nbdcache_port_ctrl: RTL and testbench

- Per-port controller of the non-blocking, write-back, set-associative L1 data cache.
- Sits between one core request port (load unit, store unit or PTW) and two blocks:
  - the shared tag-compare/SRAM arbiter;
  - the shared miss handler, which also handles MSHR checks and non-cacheable bypass.
- Serves one request at a time: looks up the tag, serves hits locally, and forwards misses or uncached accesses to the miss handler.

---
 rtl/nbdcache_port_ctrl_if.sv | 91 +++++++++
 rtl/nbdcache_port_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_nbdcache_port_ctrl.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nbdcache_port_ctrl_if.sv
// nbdcache_port_ctrl_if
// ---------------------
// Bundles every signal of one cache port controller except clock and reset:
//   - core request side : bypass_i, busy_o, req_*, addr_*, tag_valid_i,
//                         kill_req_i, we_i, wdata_i, be_i, rvalid_o, rdata_o
//   - tag/SRAM arbiter  : sram_*, hit_way_i
//   - miss handler      : mshr_*, miss_*, active_serving_i, critical_word_*,
//                         bypass_valid_i, bypass_data_i
// The _i/_o suffixes are seen from the controller.
// Modports:
//   master : the port controller (drives the *_o signals)
//   slave  : the surroundings (core, arbiter and miss handler)
// Optional: NBDCACHE_PORT_MISS_PULSE_EN adds miss_o, a one-cycle pulse for
// every cacheable miss.
interface nbdcache_port_ctrl_if #(
  parameter int SET_ASSOC   = 4,
  parameter int INDEX_WIDTH = 12,
  parameter int TAG_WIDTH   = 44,
  parameter int LINE_WIDTH  = 128
);
  logic                            bypass_i;
  logic                            busy_o;
  logic                            req_valid_i;
  logic                            req_gnt_o;
  logic [INDEX_WIDTH-1:0]          addr_index_i;
  logic [TAG_WIDTH-1:0]            addr_tag_i;
  logic                            tag_valid_i;
  logic                            kill_req_i;
  logic                            we_i;
  logic [63:0]                     wdata_i;
  logic [7:0]                      be_i;
  logic                            rvalid_o;
  logic [63:0]                     rdata_o;
  logic [SET_ASSOC-1:0]            sram_req_o;
  logic                            sram_gnt_i;
  logic [INDEX_WIDTH-1:0]          sram_addr_o;
  logic [TAG_WIDTH-1:0]            sram_tag_o;
  logic                            sram_we_o;
  logic [LINE_WIDTH-1:0]           sram_wdata_o;
  logic [LINE_WIDTH/8-1:0]         sram_be_o;
  logic                            sram_dirty_o;
  logic [SET_ASSOC*LINE_WIDTH-1:0] sram_rdata_i;
  logic [SET_ASSOC-1:0]            hit_way_i;
  logic [TAG_WIDTH+INDEX_WIDTH-1:0] mshr_addr_o;
  logic                            mshr_addr_matches_i;
  logic                            miss_valid_o;
  logic                            miss_gnt_i;
  logic [TAG_WIDTH+INDEX_WIDTH-1:0] miss_addr_o;
  logic                            miss_we_o;
  logic [63:0]                     miss_wdata_o;
  logic [7:0]                      miss_be_o;
  logic                            miss_nc_o;
  logic                            active_serving_i;
  logic [63:0]                     critical_word_i;
  logic                            critical_word_valid_i;
  logic                            bypass_valid_i;
  logic [63:0]                     bypass_data_i;
`ifdef NBDCACHE_PORT_MISS_PULSE_EN
  logic                            miss_o;
`endif

  modport master (
`ifdef NBDCACHE_PORT_MISS_PULSE_EN
    output miss_o,
`endif
    input  bypass_i, req_valid_i, addr_index_i, addr_tag_i, tag_valid_i,
           kill_req_i, we_i, wdata_i, be_i, sram_gnt_i, sram_rdata_i,
           hit_way_i, mshr_addr_matches_i, miss_gnt_i, active_serving_i,
           critical_word_i, critical_word_valid_i, bypass_valid_i,
           bypass_data_i,
    output busy_o, req_gnt_o, rvalid_o, rdata_o, sram_req_o, sram_addr_o,
           sram_tag_o, sram_we_o, sram_wdata_o, sram_be_o, sram_dirty_o,
           mshr_addr_o, miss_valid_o, miss_addr_o, miss_we_o, miss_wdata_o,
           miss_be_o, miss_nc_o
  );

  modport slave (
`ifdef NBDCACHE_PORT_MISS_PULSE_EN
    input  miss_o,
`endif
    output bypass_i, req_valid_i, addr_index_i, addr_tag_i, tag_valid_i,
           kill_req_i, we_i, wdata_i, be_i, sram_gnt_i, sram_rdata_i,
           hit_way_i, mshr_addr_matches_i, miss_gnt_i, active_serving_i,
           critical_word_i, critical_word_valid_i, bypass_valid_i,
           bypass_data_i,
    input  busy_o, req_gnt_o, rvalid_o, rdata_o, sram_req_o, sram_addr_o,
           sram_tag_o, sram_we_o, sram_wdata_o, sram_be_o, sram_dirty_o,
           mshr_addr_o, miss_valid_o, miss_addr_o, miss_we_o, miss_wdata_o,
           miss_be_o, miss_nc_o
  );
endinterface

// File: rtl/nbdcache_port_ctrl.sv
// nbdcache_port_ctrl
// ------------------
// Per-port controller of the non-blocking write-back L1 data cache. Handles
// one core request at a time: looks the line up through the shared SRAM
// arbiter, answers load hits and writes store hits locally, and hands misses
// and non-cacheable accesses to the shared miss handler.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   port         : nbdcache_port_ctrl_if.master (core request, SRAM arbiter
//                  and miss handler signals)
// Timing: handshake outputs (req_gnt_o, sram_*, mshr_*, miss_*) are decoded
// from the state; rvalid_o/rdata_o are registered, so a load hit answers two
// cycles after its grant.
// Optional: define NBDCACHE_PORT_MISS_PULSE_EN to get port.miss_o, a one-cycle
// registered pulse for every cacheable miss found in the tag lookup.
module nbdcache_port_ctrl #(
  parameter int SET_ASSOC   = 4,
  parameter int INDEX_WIDTH = 12,
  parameter int TAG_WIDTH   = 44,
  parameter int LINE_WIDTH  = 128,
  parameter int BYTE_OFFSET = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  nbdcache_port_ctrl_if.master port
);
  localparam int WORDS = LINE_WIDTH / 64;
  localparam int OFF_W = BYTE_OFFSET - 3;

  typedef enum logic [2:0] {
    IDLE, WAIT_TAG, STORE_WRITE, WAIT_MSHR,
    MISS_REQ, WAIT_CRITICAL, WAIT_REFILL, WAIT_BYPASS
  } state_e;

  state_e                 state_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   we_q;
  logic [63:0]            wdata_q;
  logic [7:0]             be_q;
  logic                   nc_q;
  logic [SET_ASSOC-1:0]   hit_way_q;
  logic                   active_serving_q;
  logic                   rvalid_q;
  logic [63:0]            rdata_q;
  logic [OFF_W-1:0]       word_sel;
  logic [63:0]            hit_word;
  logic [LINE_WIDTH/8-1:0] be_line;
`ifdef NBDCACHE_PORT_MISS_PULSE_EN
  logic                   miss_q;
`endif

  assign word_sel = index_q[BYTE_OFFSET-1:3];

  // Pick the addressed 64-bit word out of the way flagged by the one-hot hit
  // vector; with no hit the result is simply zero.
  always_comb begin
    hit_word = '0;
    for (int w = 0; w < SET_ASSOC; w++) begin
      if (port.hit_way_i[w]) begin
        hit_word = hit_word |
                   port.sram_rdata_i[w*LINE_WIDTH + 64*int'(word_sel) +: 64];
      end
    end
  end

  // A store hit writes the replicated data word across the line, so only the
  // byte enables of the addressed word may be set.
  always_comb begin
    be_line = '0;
    be_line[8*int'(word_sel) +: 8] = be_q;
  end

  // Handshake outputs toward the core, arbiter and miss handler follow the
  // state directly; everything idles at zero outside its own state.
  always_comb begin
    port.req_gnt_o    = 1'b0;
    port.sram_req_o   = '0;
    port.sram_addr_o  = '0;
    port.sram_tag_o   = '0;
    port.sram_we_o    = 1'b0;
    port.sram_wdata_o = '0;
    port.sram_be_o    = '0;
    port.sram_dirty_o = 1'b0;
    port.mshr_addr_o  = '0;
    port.miss_valid_o = 1'b0;
    port.miss_addr_o  = '0;
    port.miss_we_o    = 1'b0;
    port.miss_wdata_o = '0;
    port.miss_be_o    = '0;
    port.miss_nc_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (port.req_valid_i) begin
          port.sram_req_o  = '1;
          port.sram_addr_o = port.addr_index_i;
          port.req_gnt_o   = port.sram_gnt_i;
        end
      end
      WAIT_TAG: begin
        port.sram_addr_o = index_q;
        port.sram_tag_o  = port.addr_tag_i;
      end
      STORE_WRITE: begin
        port.sram_req_o   = hit_way_q;
        port.sram_addr_o  = index_q;
        port.sram_tag_o   = tag_q;
        port.sram_we_o    = 1'b1;
        port.sram_dirty_o = 1'b1;
        port.sram_wdata_o = {WORDS{wdata_q}};
        port.sram_be_o    = be_line;
      end
      WAIT_MSHR: begin
        port.mshr_addr_o = {tag_q, index_q};
      end
      MISS_REQ: begin
        port.miss_valid_o = 1'b1;
        port.miss_addr_o  = {tag_q, index_q};
        port.miss_we_o    = we_q;
        port.miss_wdata_o = wdata_q;
        port.miss_be_o    = be_q;
        port.miss_nc_o    = nc_q;
      end
      default: ;
    endcase
  end

  assign port.busy_o   = (state_q != IDLE);
  assign port.rvalid_o = rvalid_q;
  assign port.rdata_o  = rdata_q;
`ifdef NBDCACHE_PORT_MISS_PULSE_EN
  assign port.miss_o   = miss_q;
`endif

  // Main sequencer: latches the accepted request, walks it through lookup,
  // store write or miss handling, and issues exactly one response pulse.
  // The response registers default to zero every cycle so rvalid_o stays a
  // single-cycle pulse. active_serving_q remembers last cycle's value so the
  // end of a store refill can be seen as a falling edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      index_q          <= '0;
      tag_q            <= '0;
      we_q             <= 1'b0;
      wdata_q          <= '0;
      be_q             <= '0;
      nc_q             <= 1'b0;
      hit_way_q        <= '0;
      active_serving_q <= 1'b0;
      rvalid_q         <= 1'b0;
      rdata_q          <= '0;
`ifdef NBDCACHE_PORT_MISS_PULSE_EN
      miss_q           <= 1'b0;
`endif
    end else begin
      rvalid_q         <= 1'b0;
      rdata_q          <= '0;
      active_serving_q <= port.active_serving_i;
`ifdef NBDCACHE_PORT_MISS_PULSE_EN
      miss_q           <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (port.req_valid_i && port.sram_gnt_i) begin
            index_q <= port.addr_index_i;
            we_q    <= port.we_i;
            wdata_q <= port.wdata_i;
            be_q    <= port.be_i;
            nc_q    <= 1'b0;
            state_q <= WAIT_TAG;
          end
        end
        WAIT_TAG: begin
          if (port.kill_req_i) begin
            state_q <= IDLE;
          end else if (port.tag_valid_i) begin
            tag_q     <= port.addr_tag_i;
            hit_way_q <= port.hit_way_i;
            if (port.bypass_i) begin
              nc_q    <= 1'b1;
              state_q <= MISS_REQ;
            end else if (|port.hit_way_i) begin
              if (we_q) begin
                state_q <= STORE_WRITE;
              end else begin
                rvalid_q <= 1'b1;
                rdata_q  <= hit_word;
                state_q  <= IDLE;
              end
            end else begin
`ifdef NBDCACHE_PORT_MISS_PULSE_EN
              miss_q  <= 1'b1;
`endif
              state_q <= WAIT_MSHR;
            end
          end
        end
        STORE_WRITE: begin
          if (port.sram_gnt_i) begin
            rvalid_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        WAIT_MSHR: begin
          if (!port.mshr_addr_matches_i) state_q <= MISS_REQ;
        end
        MISS_REQ: begin
          if (port.miss_gnt_i) begin
            if (nc_q)      state_q <= WAIT_BYPASS;
            else if (we_q) state_q <= WAIT_REFILL;
            else           state_q <= WAIT_CRITICAL;
          end
        end
        WAIT_CRITICAL: begin
          if (port.critical_word_valid_i) begin
            rvalid_q <= 1'b1;
            rdata_q  <= port.critical_word_i;
            state_q  <= IDLE;
          end
        end
        WAIT_REFILL: begin
          if (active_serving_q && !port.active_serving_i) begin
            rvalid_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        WAIT_BYPASS: begin
          if (port.bypass_valid_i) begin
            rvalid_q <= 1'b1;
            rdata_q  <= we_q ? 64'h0 : port.bypass_data_i;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nbdcache_port_ctrl.sv
// tb_nbdcache_port_ctrl
// ---------------------
// Self-checking bench for nbdcache_port_ctrl. Each scenario task drives one
// request, pushes the response it expects into a scoreboard queue and pops it
// when rvalid_o shows up. Inputs change 1 ns after the rising edge and
// outputs are sampled 1 ns after that.
module tb_nbdcache_port_ctrl;
  localparam int SET_ASSOC   = 4;
  localparam int INDEX_WIDTH = 12;
  localparam int TAG_WIDTH   = 44;
  localparam int LINE_WIDTH  = 128;
  localparam int BYTE_OFFSET = 4;

  typedef struct packed {
    logic        check_data;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  exp_t e;

  nbdcache_port_ctrl_if #(
    .SET_ASSOC(SET_ASSOC), .INDEX_WIDTH(INDEX_WIDTH),
    .TAG_WIDTH(TAG_WIDTH), .LINE_WIDTH(LINE_WIDTH)
  ) bus ();

  nbdcache_port_ctrl #(
    .SET_ASSOC(SET_ASSOC), .INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH),
    .LINE_WIDTH(LINE_WIDTH), .BYTE_OFFSET(BYTE_OFFSET)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .port (bus)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Return every controller input to its quiet value.
  task automatic clear_inputs();
    bus.bypass_i              = 1'b0;
    bus.req_valid_i           = 1'b0;
    bus.addr_index_i          = '0;
    bus.addr_tag_i            = '0;
    bus.tag_valid_i           = 1'b0;
    bus.kill_req_i            = 1'b0;
    bus.we_i                  = 1'b0;
    bus.wdata_i               = '0;
    bus.be_i                  = '0;
    bus.sram_gnt_i            = 1'b0;
    bus.sram_rdata_i          = '0;
    bus.hit_way_i             = '0;
    bus.mshr_addr_matches_i   = 1'b0;
    bus.miss_gnt_i            = 1'b0;
    bus.active_serving_i      = 1'b0;
    bus.critical_word_i       = '0;
    bus.critical_word_valid_i = 1'b0;
    bus.bypass_valid_i        = 1'b0;
    bus.bypass_data_i         = '0;
  endtask

  // Present a request together with an arbiter grant.
  task automatic drive_request(input logic [INDEX_WIDTH-1:0] idx, input logic we,
                               input logic [63:0] wd, input logic [7:0] be);
    bus.req_valid_i  = 1'b1;
    bus.addr_index_i = idx;
    bus.we_i         = we;
    bus.wdata_i      = wd;
    bus.be_i         = be;
    bus.sram_gnt_i   = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    vectors++;
    if (bus.busy_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_busy: got %b, want 0", bus.busy_o);
    end
    vectors++;
    if (bus.rvalid_o !== 1'b0 || bus.rdata_o !== 64'h0) begin
      miscompares++; $display("[TB] FAIL reset_resp: rvalid=%b rdata=%h, want 0/0", bus.rvalid_o, bus.rdata_o);
    end
    vectors++;
    if (bus.sram_req_o !== 4'h0 || bus.miss_valid_o !== 1'b0 || bus.req_gnt_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_handshake: sram_req=%b miss_valid=%b gnt=%b, want 0", bus.sram_req_o, bus.miss_valid_o, bus.req_gnt_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_hit();
    cycle();
    drive_request(12'h018, 1'b0, 64'h0, 8'h00);
    #1;
    vectors++;
    if (bus.req_gnt_o !== 1'b1 || bus.sram_req_o !== 4'hF || bus.sram_addr_o !== 12'h018 || bus.sram_we_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL load_hit_lookup: gnt=%b req=%b addr=%h we=%b, want 1/1111/018/0", bus.req_gnt_o, bus.sram_req_o, bus.sram_addr_o, bus.sram_we_o);
    end
    exp_q.push_back({1'b1, 64'hDEAD});
    cycle();
    clear_inputs();
    bus.addr_tag_i  = 44'h5;
    bus.tag_valid_i = 1'b1;
    bus.hit_way_i   = 4'b0010;
    bus.sram_rdata_i[LINE_WIDTH+64 +: 64] = 64'hDEAD;
    bus.sram_rdata_i[LINE_WIDTH +: 64]    = 64'h1111;
    bus.sram_rdata_i[64 +: 64]            = 64'h2222;
    #1;
    vectors++;
    if (bus.sram_tag_o !== 44'h5 || bus.rvalid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL load_hit_tag: sram_tag=%h rvalid=%b, want 5/0", bus.sram_tag_o, bus.rvalid_o);
    end
    cycle();
    clear_inputs();
    #1;
    vectors++;
    if (bus.rvalid_o !== 1'b1 || exp_q.size() == 0) begin
      miscompares++; $display("[TB] FAIL load_hit_rvalid: rvalid=%b queued=%0d, want 1 with one queued", bus.rvalid_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      vectors++;
      if (e.check_data && bus.rdata_o !== e.data) begin
        miscompares++; $display("[TB] FAIL load_hit_rdata: got %h, want %h", bus.rdata_o, e.data);
      end
    end
    vectors++;
    if (bus.busy_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL load_hit_idle: busy=%b, want 0", bus.busy_o);
    end
    cycle();
    vectors++;
    if (bus.rvalid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL load_hit_pulse: rvalid=%b, want 0", bus.rvalid_o);
    end
  endtask

  task automatic test_store_hit();
    cycle();
    drive_request(12'h008, 1'b1, 64'h1234, 8'h0F);
    #1;
    vectors++;
    if (bus.req_gnt_o !== 1'b1) begin
      miscompares++; $display("[TB] FAIL store_hit_gnt: got %b, want 1", bus.req_gnt_o);
    end
    exp_q.push_back({1'b0, 64'h0});
    cycle();
    clear_inputs();
    bus.addr_tag_i  = 44'h6;
    bus.tag_valid_i = 1'b1;
    bus.hit_way_i   = 4'b0001;
    cycle();
    clear_inputs();
    #1;
    vectors++;
    if (bus.sram_we_o !== 1'b1 || bus.sram_dirty_o !== 1'b1 || bus.sram_req_o !== 4'b0001) begin
      miscompares++; $display("[TB] FAIL store_hit_write: we=%b dirty=%b req=%b, want 1/1/0001", bus.sram_we_o, bus.sram_dirty_o, bus.sram_req_o);
    end
    vectors++;
    if (bus.sram_be_o !== 16'h0F00 || bus.sram_wdata_o !== {2{64'h1234}} || bus.sram_addr_o !== 12'h008) begin
      miscompares++; $display("[TB] FAIL store_hit_data: be=%h wdata=%h addr=%h, want 0f00/%h/008", bus.sram_be_o, bus.sram_wdata_o, bus.sram_addr_o, {2{64'h1234}});
    end
    vectors++;
    if (bus.rvalid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL store_hit_early: rvalid=%b before grant, want 0", bus.rvalid_o);
    end
    cycle();
    bus.sram_gnt_i = 1'b1;
    cycle();
    clear_inputs();
    #1;
    vectors++;
    if (bus.rvalid_o !== 1'b1 || exp_q.size() == 0) begin
      miscompares++; $display("[TB] FAIL store_hit_ack: rvalid=%b queued=%0d, want 1 with one queued", bus.rvalid_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      vectors++;
      if (e.check_data && bus.rdata_o !== e.data) begin
        miscompares++; $display("[TB] FAIL store_hit_rdata: got %h, want %h", bus.rdata_o, e.data);
      end
    end
    vectors++;
    if (bus.sram_we_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL store_hit_done: we=%b busy=%b, want 0/0", bus.sram_we_o, bus.busy_o);
    end
  endtask

  task automatic test_miss_mshr();
    cycle();
    drive_request(12'h010, 1'b0, 64'h0, 8'h00);
    exp_q.push_back({1'b1, 64'hCAFE});
    cycle();
    clear_inputs();
    bus.addr_tag_i          = 44'h7;
    bus.tag_valid_i         = 1'b1;
    bus.mshr_addr_matches_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      clear_inputs();
      bus.mshr_addr_matches_i = 1'b1;
      drive_request(12'h3F0, 1'b0, 64'h0, 8'h00);
      #1;
      vectors++;
      if (bus.miss_valid_o !== 1'b0 || bus.mshr_addr_o !== {44'h7, 12'h010}) begin
        miscompares++; $display("[TB] FAIL miss_mshr_hold%0d: miss_valid=%b mshr_addr=%h, want 0/%h", i, bus.miss_valid_o, bus.mshr_addr_o, {44'h7, 12'h010});
      end
      vectors++;
      if (bus.req_gnt_o !== 1'b0 || bus.sram_req_o !== 4'h0) begin
        miscompares++; $display("[TB] FAIL miss_busy_gnt%0d: gnt=%b sram_req=%b, want 0/0000", i, bus.req_gnt_o, bus.sram_req_o);
      end
    end
    cycle();
    clear_inputs();
    #1;
    vectors++;
    if (bus.miss_valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL miss_mshr_release: miss_valid=%b, want 0", bus.miss_valid_o);
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      vectors++;
      if (bus.miss_valid_o !== 1'b1 || bus.miss_addr_o !== {44'h7, 12'h010} || bus.miss_nc_o !== 1'b0 || bus.miss_we_o !== 1'b0) begin
        miscompares++; $display("[TB] FAIL miss_req%0d: valid=%b addr=%h nc=%b we=%b, want 1/%h/0/0", i, bus.miss_valid_o, bus.miss_addr_o, bus.miss_nc_o, bus.miss_we_o, {44'h7, 12'h010});
      end
    end
    bus.miss_gnt_i = 1'b1;
    cycle();
    clear_inputs();
    #1;
    vectors++;
    if (bus.miss_valid_o !== 1'b0 || bus.rvalid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      miscompares++; $display("[TB] FAIL miss_wait_crit: miss_valid=%b rvalid=%b busy=%b, want 0/0/1", bus.miss_valid_o, bus.rvalid_o, bus.busy_o);
    end
    cycle();
    bus.critical_word_i       = 64'hCAFE;
    bus.critical_word_valid_i = 1'b1;
    cycle();
    clear_inputs();
    #1;
    vectors++;
    if (bus.rvalid_o !== 1'b1 || exp_q.size() == 0) begin
      miscompares++; $display("[TB] FAIL miss_rvalid: rvalid=%b queued=%0d, want 1 with one queued", bus.rvalid_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      vectors++;
      if (e.check_data && bus.rdata_o !== e.data) begin
        miscompares++; $display("[TB] FAIL miss_rdata: got %h, want %h", bus.rdata_o, e.data);
      end
    end
  endtask

  task automatic test_kill();
    cycle();
    drive_request(12'h020, 1'b0, 64'h0, 8'h00);
    cycle();
    clear_inputs();
    bus.addr_tag_i  = 44'h1;
    bus.tag_valid_i = 1'b1;
    bus.hit_way_i   = 4'b0001;
    bus.kill_req_i  = 1'b1;
    cycle();
    clear_inputs();
    #1;
    vectors++;
    if (bus.busy_o !== 1'b0 || bus.rvalid_o !== 1'b0 || bus.miss_valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL kill: busy=%b rvalid=%b miss_valid=%b, want 0/0/0", bus.busy_o, bus.rvalid_o, bus.miss_valid_o);
    end
    cycle();
    vectors++;
    if (bus.rvalid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL kill_late_resp: rvalid=%b, want 0", bus.rvalid_o);
    end
  endtask

  task automatic test_bypass();
    cycle();
    drive_request(12'h030, 1'b0, 64'h0, 8'h00);
    bus.bypass_i = 1'b1;
    exp_q.push_back({1'b1, 64'hBEEF});
    cycle();
    clear_inputs();
    bus.bypass_i    = 1'b1;
    bus.addr_tag_i  = 44'h9;
    bus.tag_valid_i = 1'b1;
    bus.hit_way_i   = 4'b0001;
    cycle();
    clear_inputs();
    bus.bypass_i = 1'b1;
    #1;
    vectors++;
    if (bus.miss_valid_o !== 1'b1 || bus.miss_nc_o !== 1'b1 || bus.miss_addr_o !== {44'h9, 12'h030}) begin
      miscompares++; $display("[TB] FAIL bypass_req: valid=%b nc=%b addr=%h, want 1/1/%h", bus.miss_valid_o, bus.miss_nc_o, bus.miss_addr_o, {44'h9, 12'h030});
    end
    bus.miss_gnt_i = 1'b1;
    cycle();
    bus.miss_gnt_i     = 1'b0;
    bus.bypass_valid_i = 1'b1;
    bus.bypass_data_i  = 64'hBEEF;
    cycle();
    clear_inputs();
    #1;
    vectors++;
    if (bus.rvalid_o !== 1'b1 || exp_q.size() == 0) begin
      miscompares++; $display("[TB] FAIL bypass_rvalid: rvalid=%b queued=%0d, want 1 with one queued", bus.rvalid_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      vectors++;
      if (e.check_data && bus.rdata_o !== e.data) begin
        miscompares++; $display("[TB] FAIL bypass_rdata: got %h, want %h", bus.rdata_o, e.data);
      end
    end
  endtask

  task automatic test_store_miss();
    cycle();
    drive_request(12'h048, 1'b1, 64'hA5A5, 8'h3C);
    exp_q.push_back({1'b0, 64'h0});
    cycle();
    clear_inputs();
    bus.addr_tag_i  = 44'h3;
    bus.tag_valid_i = 1'b1;
    cycle();
    clear_inputs();
    cycle();
    vectors++;
    if (bus.miss_valid_o !== 1'b1 || bus.miss_we_o !== 1'b1 || bus.miss_wdata_o !== 64'hA5A5 || bus.miss_be_o !== 8'h3C) begin
      miscompares++; $display("[TB] FAIL store_miss_req: valid=%b we=%b wdata=%h be=%h, want 1/1/a5a5/3c", bus.miss_valid_o, bus.miss_we_o, bus.miss_wdata_o, bus.miss_be_o);
    end
    bus.miss_gnt_i = 1'b1;
    cycle();
    clear_inputs();
    bus.active_serving_i = 1'b1;
    cycle();
    vectors++;
    if (bus.rvalid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL store_miss_early: rvalid=%b while refilling, want 0", bus.rvalid_o);
    end
    cycle();
    bus.active_serving_i = 1'b0;
    #1;
    vectors++;
    if (bus.rvalid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL store_miss_edge: rvalid=%b on falling edge, want 0", bus.rvalid_o);
    end
    cycle();
    vectors++;
    if (bus.rvalid_o !== 1'b1 || exp_q.size() == 0) begin
      miscompares++; $display("[TB] FAIL store_miss_ack: rvalid=%b queued=%0d, want 1 with one queued", bus.rvalid_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset_mid();
    cycle();
    drive_request(12'h050, 1'b0, 64'h0, 8'h00);
    cycle();
    clear_inputs();
    bus.addr_tag_i  = 44'h2;
    bus.tag_valid_i = 1'b1;
    cycle();
    clear_inputs();
    cycle();
    bus.miss_gnt_i = 1'b1;
    cycle();
    clear_inputs();
    #1;
    vectors++;
    if (bus.busy_o !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_mid_pre: busy=%b in WAIT_CRITICAL, want 1", bus.busy_o);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.busy_o !== 1'b0 || bus.rvalid_o !== 1'b0 || bus.miss_valid_o !== 1'b0 || bus.sram_req_o !== 4'h0 || bus.mshr_addr_o !== '0 || bus.rdata_o !== 64'h0) begin
      miscompares++; $display("[TB] FAIL reset_mid_outputs: busy=%b rvalid=%b miss_valid=%b sram_req=%b, want all 0", bus.busy_o, bus.rvalid_o, bus.miss_valid_o, bus.sram_req_o);
    end
    cycle();
    cycle();
    rst = 1'b0;
    bus.critical_word_i       = 64'h77;
    bus.critical_word_valid_i = 1'b1;
    cycle();
    clear_inputs();
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (bus.rvalid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
        miscompares++; $display("[TB] FAIL reset_mid_after%0d: rvalid=%b busy=%b, want 0/0", i, bus.rvalid_o, bus.busy_o);
      end
      cycle();
    end
  endtask

  // Bounded run: should never trigger, but keeps a broken design from hanging.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting nbdcache_port_ctrl bench");
    test_reset();
    test_load_hit();
    test_store_hit();
    test_miss_mshr();
    test_kill();
    test_bypass();
    test_store_miss();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("[TB] FAIL scoreboard_drain: %0d responses outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
